// File: rtl/trace_monitor_multi.sv
// trace_monitor_multi: per-core r3 shadow, l.nop exit/putc hook decode, termination/timeout flags and RR putc serialiser; optional TRACE_MONITOR_INSN_COUNT_EN adds retired-instruction counters
module trace_monitor_multi #(
  parameter int NUM_CORES       = 1,
  parameter int TERM_CROSS_NUM  = NUM_CORES,
  parameter int PUTC_FIFO_DEPTH = 4,
  parameter int TIMEOUT_CYCLES  = 0,
  parameter int CNT_WIDTH       = 32
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [NUM_CORES-1:0]           trace_valid,
  input  logic [NUM_CORES-1:0]           trace_wben,
  input  logic [5*NUM_CORES-1:0]         trace_wbreg,
  input  logic [32*NUM_CORES-1:0]        trace_wbdata,
  input  logic [32*NUM_CORES-1:0]        trace_insn,
  output logic [NUM_CORES-1:0]           core_done,
  output logic                           all_done,
  output logic [32*NUM_CORES-1:0]        exit_code,
  output logic                           timeout,
  output logic                           putc_valid,
  input  logic                           putc_ready,
  output logic [$clog2(NUM_CORES):0]     putc_core,
  output logic [7:0]                     putc_char,
  output logic [NUM_CORES-1:0]           putc_overflow,
  output logic [CNT_WIDTH*NUM_CORES-1:0] insn_count
);
  localparam int AW = $clog2(PUTC_FIFO_DEPTH);
  localparam int CW = $clog2(NUM_CORES) + 1;
  localparam int TW = TIMEOUT_CYCLES > 0 ? $clog2(TIMEOUT_CYCLES + 1) : 1;
  localparam logic [AW:0]   FULL  = PUTC_FIFO_DEPTH[AW:0];
  localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT_CYCLES - 1);

  typedef enum logic {RUN = 1'b0, DONE = 1'b1} state_t;

  logic [NUM_CORES-1:0] pop, nonempty;
  logic [7:0]           head [NUM_CORES];

  for (genvar i = 0; i < NUM_CORES; i++) begin : g_core
    state_t      state_q, state_d;
    logic        done;
    logic [31:0] r3_q, r3_d, exit_q, exit_d;
    logic [7:0]  mem_q [PUTC_FIFO_DEPTH];
    logic [7:0]  mem_d [PUTC_FIFO_DEPTH];
    logic [AW-1:0] wp_q, wp_d, rp_q, rp_d;
    logic [AW:0] cnt_q, cnt_d;
    logic        ovf_q, ovf_d;
    logic        hook, is_exit, is_putc, push_ok, unused_bits;
    assign hook        = trace_valid[i] && trace_insn[32*i+24 +: 8] == 8'h15;
    assign is_exit     = hook && trace_insn[32*i +: 16] == 16'd1;
    assign is_putc     = hook && trace_insn[32*i +: 16] == 16'd4;
    assign push_ok     = is_putc && (cnt_q != FULL || pop[i]);
    assign unused_bits = ^trace_insn[32*i+16 +: 8];
    // RUN moves to terminal DONE on the first exit hook
    always_comb state_d = (state_q == RUN && is_exit) ? DONE : state_q;
    // core_done mirrors the DONE state
    always_comb done = state_q == DONE;
    // shadow r3, exit capture from pre-write r3, and character FIFO bookkeeping
    always_comb begin
      r3_d   = (trace_valid[i] && trace_wben[i] && trace_wbreg[5*i +: 5] == 5'd3) ? trace_wbdata[32*i +: 32] : r3_q;
      exit_d = (state_q == RUN && is_exit) ? r3_q : exit_q;
      wp_d   = push_ok ? wp_q + 1'b1 : wp_q;
      rp_d   = pop[i] ? rp_q + 1'b1 : rp_q;
      cnt_d  = cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop[i]};
      ovf_d  = ovf_q | (is_putc & ~push_ok);
      mem_d  = mem_q;
      if (push_ok) mem_d[wp_q] = r3_q[7:0];
    end
    // per-core state register
    always_ff @(posedge clk) begin
      if (!rst) begin
        state_q <= RUN;
        r3_q    <= '0;
        exit_q  <= '0;
        mem_q   <= '{default: '0};
        wp_q    <= '0;
        rp_q    <= '0;
        cnt_q   <= '0;
        ovf_q   <= 1'b0;
      end else begin
        state_q <= state_d;
        r3_q    <= r3_d;
        exit_q  <= exit_d;
        mem_q   <= mem_d;
        wp_q    <= wp_d;
        rp_q    <= rp_d;
        cnt_q   <= cnt_d;
        ovf_q   <= ovf_d;
      end
    end
    assign core_done[i]            = done;
    assign exit_code[32*i +: 32]   = exit_q;
    assign putc_overflow[i]        = ovf_q;
    assign nonempty[i]             = cnt_q != '0;
    assign head[i]                 = mem_q[rp_q];
`ifdef TRACE_MONITOR_INSN_COUNT_EN
    logic [CNT_WIDTH-1:0] ic_q, ic_d;
    // count retirements while running, the exit nop included
    always_comb ic_d = (trace_valid[i] && state_q == RUN) ? ic_q + 1'b1 : ic_q;
    // instruction counter register
    always_ff @(posedge clk) ic_q <= !rst ? '0 : ic_d;
    assign insn_count[CNT_WIDTH*i +: CNT_WIDTH] = ic_q;
`else
    assign insn_count[CNT_WIDTH*i +: CNT_WIDTH] = '0;
`endif
  end

  int          ndone, lo, hi, sel;
  logic        any_lo, any_hi, grant;
  logic        all_done_q, all_done_d, to_q, to_d, valid_q, valid_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic [CW-1:0] rr_q, rr_d, core_q, core_d;
  logic [7:0]  char_q, char_d, sel_char;

  // sticky termination and timeout from a saturating cycle counter
  always_comb begin
    ndone = 0;
    for (int j = 0; j < NUM_CORES; j++) ndone = ndone + (core_done[j] ? 1 : 0);
    all_done_d = all_done_q | (ndone >= TERM_CROSS_NUM);
    tcnt_d     = tcnt_q == TMAX ? tcnt_q : tcnt_q + 1'b1;
    to_d       = to_q | (TIMEOUT_CYCLES != 0 && tcnt_q == TLAST && !all_done_q);
  end

  // round-robin search: first non-empty FIFO at or above rr_q, else lowest non-empty
  always_comb begin
    lo = 0;
    hi = 0;
    any_lo = 1'b0;
    any_hi = 1'b0;
    for (int j = NUM_CORES - 1; j >= 0; j--) begin
      if (nonempty[j]) begin
        lo = j;
        any_lo = 1'b1;
      end
      if (nonempty[j] && j >= int'(rr_q)) begin
        hi = j;
        any_hi = 1'b1;
      end
    end
    sel = any_hi ? hi : lo;
  end

  // holding slot loads when empty or draining, popping the granted FIFO
  always_comb begin
    grant    = (!valid_q || putc_ready) && any_lo;
    pop      = '0;
    sel_char = '0;
    for (int j = 0; j < NUM_CORES; j++) begin
      pop[j] = grant && j == sel;
      if (j == sel) sel_char = head[j];
    end
    valid_d = grant | (valid_q & ~putc_ready);
    core_d  = grant ? CW'(sel) : core_q;
    char_d  = grant ? sel_char : char_q;
    rr_d    = !grant ? rr_q : sel == NUM_CORES - 1 ? '0 : CW'(sel + 1);
  end

  // global state register
  always_ff @(posedge clk) begin
    if (!rst) begin
      all_done_q <= 1'b0;
      to_q       <= 1'b0;
      tcnt_q     <= '0;
      valid_q    <= 1'b0;
      rr_q       <= '0;
      core_q     <= '0;
      char_q     <= '0;
    end else begin
      all_done_q <= all_done_d;
      to_q       <= to_d;
      tcnt_q     <= tcnt_d;
      valid_q    <= valid_d;
      rr_q       <= rr_d;
      core_q     <= core_d;
      char_q     <= char_d;
    end
  end

  assign all_done   = all_done_q;
  assign timeout    = to_q;
  assign putc_valid = valid_q;
  assign putc_core  = core_q;
  assign putc_char  = char_q;
endmodule

// File: tb/tb_trace_monitor_multi.sv
// tb_trace_monitor_multi: directed checks of a 1-core and a 4-core trace_monitor_multi
module tb_trace_monitor_multi;
  localparam logic [31:0] PLAIN = 32'hE0000000;
  localparam logic [31:0] EXIT  = 32'h15000001;
  localparam logic [31:0] PUTC  = 32'h15000004;
`ifdef TRACE_MONITOR_INSN_COUNT_EN
  localparam logic [31:0] IC11 = 32'd11;
`else
  localparam logic [31:0] IC11 = 32'd0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic v1, w1, cd1, ad1, to1, pv1, pr1, pc1, po1;
  logic [4:0] r1;
  logic [31:0] d1, i1, ec1, ic1;
  logic [7:0] ch1;
  logic [3:0] v4, w4, cd4, po4;
  logic [19:0] r4;
  logic [127:0] d4, i4, ec4, ic4;
  logic ad4, to4, pv4, pr4;
  logic [2:0] pc4;
  logic [7:0] ch4;

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  trace_monitor_multi #(.NUM_CORES(1), .TERM_CROSS_NUM(1), .PUTC_FIFO_DEPTH(4), .TIMEOUT_CYCLES(100), .CNT_WIDTH(32)) u_dut1 (
    .clk(clk), .rst(rst), .trace_valid(v1), .trace_wben(w1), .trace_wbreg(r1), .trace_wbdata(d1), .trace_insn(i1),
    .core_done(cd1), .all_done(ad1), .exit_code(ec1), .timeout(to1), .putc_valid(pv1), .putc_ready(pr1),
    .putc_core(pc1), .putc_char(ch1), .putc_overflow(po1), .insn_count(ic1));

  trace_monitor_multi #(.NUM_CORES(4), .TERM_CROSS_NUM(3), .PUTC_FIFO_DEPTH(4), .TIMEOUT_CYCLES(100), .CNT_WIDTH(32)) u_dut4 (
    .clk(clk), .rst(rst), .trace_valid(v4), .trace_wben(w4), .trace_wbreg(r4), .trace_wbdata(d4), .trace_insn(i4),
    .core_done(cd4), .all_done(ad4), .exit_code(ec4), .timeout(to4), .putc_valid(pv4), .putc_ready(pr4),
    .putc_core(pc4), .putc_char(ch4), .putc_overflow(po4), .insn_count(ic4));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic clr();
    v1 = 0; w1 = 0; r1 = 0; d1 = 0; i1 = 0;
    v4 = 0; w4 = 0; r4 = 0; d4 = 0; i4 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    cyc++;
    clr();
  endtask

  task automatic op1(input logic [31:0] insn, input logic wr, input logic [31:0] data);
    v1 = 1; i1 = insn; w1 = wr; r1 = 5'd3; d1 = data;
  endtask

  task automatic op4(input int c, input logic [31:0] insn, input logic wr, input logic [31:0] data);
    v4[c] = 1'b1; i4[32*c +: 32] = insn; w4[c] = wr; r4[5*c +: 5] = 5'd3; d4[32*c +: 32] = data;
  endtask

  initial begin
    rst = 0; pr1 = 1; pr4 = 1; clr();
    repeat (2) @(posedge clk);
    #1;
    check("rst_done", {cd1, cd4}, 0);
    check("rst_all", {ad1, ad4}, 0);
    check("rst_exit", {31'd0, |{ec1, ec4}}, 0);
    check("rst_timeout", {to1, to4}, 0);
    check("rst_putc4", {pv4, pc4, ch4}, 0);
    check("rst_putc1", {pv1, pc1, ch1}, 0);
    check("rst_ovf", {po1, po4}, 0);
    check("rst_icnt", {31'd0, |{ic1, ic4}}, 0);
    rst = 1;
    cyc = 0;

    op4(0, PLAIN, 1, 32'h41); op4(1, PLAIN, 1, 32'h41); step();
    op4(0, PUTC, 1, 32'h42); op4(1, PUTC, 1, 32'h42); step();
    check("ab_lat", {pv4}, 0);
    op4(0, PUTC, 0, 0); op4(1, PUTC, 0, 0); step();
    check("ab_0A", {pv4, pc4, ch4}, {1'b1, 3'd0, 8'h41});
    step();
    check("ab_1A", {pv4, pc4, ch4}, {1'b1, 3'd1, 8'h41});
    step();
    check("ab_0B", {pv4, pc4, ch4}, {1'b1, 3'd0, 8'h42});
    step();
    check("ab_1B", {pv4, pc4, ch4}, {1'b1, 3'd1, 8'h42});
    step();
    check("ab_empty", {pv4}, 0);

    pr4 = 0;
    op4(1, PLAIN, 1, 32'h30); step();
    for (int k = 0; k < 6; k++) begin
      op4(1, PUTC, 1, 32'h31 + k); step();
      if (k == 4) check("ovf_before", {po4}, 4'b0000);
    end
    check("ovf_set", {po4}, 4'b0010);
    for (int k = 0; k < 5; k++) begin
      step();
      check("hold", {pv4, pc4, ch4}, {1'b1, 3'd1, 8'h30});
    end
    pr4 = 1;
    for (int k = 0; k < 4; k++) begin
      step();
      check("drain", {pv4, pc4, ch4}, {1'b1, 3'd1, 8'h31 + 8'(k)});
    end
    step();
    check("drain_end", {pv4}, 0);
    check("ovf_sticky", {po4}, 4'b0010);

    op4(3, 32'h15000002, 0, 0); step();
    op4(3, 32'h14000001, 0, 0); step();
    step();
    check("otherk", {pv4, cd4}, 0);

    while (cyc < 40) step();
    for (int k = 0; k < 9; k++) begin
      op1(PLAIN, 0, 0); step();
    end
    op1(PLAIN, 1, 32'h2A); step();
    check("c1_prexit", {cd1}, 0);
    op1(EXIT, 0, 0); step();
    check("c1_done", {cd1, ad1}, 2'b10);
    check("c1_code", ec1, 32'h2A);
    step();
    check("c1_all", {ad1}, 1);
    check("c1_icnt", ic1, IC11);
    op1(PLAIN, 1, 32'h55); step();
    op1(EXIT, 0, 0); step();
    op1(PLAIN, 0, 0); step();
    check("c1_code_hold", ec1, 32'h2A);
    check("c1_icnt_frozen", ic1, IC11);

    while (cyc < 99) step();
    check("to_pre", {to4}, 0);
    step();
    check("to_fire", {to4}, 1);
    check("to_masked", {to1}, 0);

    op4(0, PLAIN, 1, 32'h3); op4(2, PLAIN, 1, 32'h22); op4(3, PLAIN, 1, 32'h33); step();
    op4(0, EXIT, 1, 32'h7); step();
    check("x0_done", {cd4}, 4'b0001);
    check("x0_code", ec4[31:0], 32'h3);
    op4(2, EXIT, 0, 0); step();
    check("x2_done", {cd4, ad4}, {4'b0101, 1'b0});
    op4(3, EXIT, 0, 0); step();
    check("x3_done", {cd4, ad4}, {4'b1101, 1'b0});
    check("x3_code", ec4[127:96], 32'h33);
    step();
    check("all3", {ad4}, 1);
    op4(2, PLAIN, 1, 32'h99); step();
    op4(2, EXIT, 0, 0); step();
    step();
    check("x2_code_hold", ec4[95:64], 32'h22);
    check("x_final", {cd4, ad4}, {4'b1101, 1'b1});

    pr4 = 0;
    op4(1, PLAIN, 1, 32'h77); step();
    op4(1, PUTC, 1, 32'h78); step();
    op4(1, PUTC, 0, 0); step();
    check("pre_rst", {pv4, ch4}, {1'b1, 8'h77});
    rst = 0; step();
    check("mid_rst", {pv4, po4, cd4, ad4, to4}, 0);
    rst = 1; pr4 = 1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("post_rst", {pv4}, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/trace_monitor_multi.md
Name: trace_monitor_multi

Overview:
- Synthesizable, parametrised successor to the per-core r3 checker / software tracer pair used by the compute-tile benches.
- Watches NUM_CORES mor1kx execution-trace channels and keeps a shadow r3 per core.
- Decodes l.nop simulation hooks (exit, putc) and produces per-core and global termination, exit codes and a timeout flag.
- Serialises putc characters from all cores onto one valid/ready stream, so it can feed a debug-system or UART sink on FPGA as well as in simulation.

Parameters:
- NUM_CORES, 1: number of monitored trace channels (1..32).
- TERM_CROSS_NUM, NUM_CORES: number of exited cores needed to raise all_done (1..NUM_CORES).
- PUTC_FIFO_DEPTH, 4: per-core character FIFO depth; power of two, >=2.
- TIMEOUT_CYCLES, 0: cycles after reset before timeout is raised; 0 disables the timeout.
- CNT_WIDTH, 32: instruction counter width.

Ports:
- clk  input  1  system clock
- rst  input  1  reset; synchronous, active-low (asserted when 0)
- trace_valid  input  NUM_CORES  retired-instruction strobe per core
- trace_wben  input  NUM_CORES  register writeback enable per core
- trace_wbreg  input  5*NUM_CORES  writeback register index, core i at [5i+:5]
- trace_wbdata  input  32*NUM_CORES  writeback data
- trace_insn  input  32*NUM_CORES  retired instruction word
- core_done  output  NUM_CORES  core has executed exit nop
- all_done  output  1  at least TERM_CROSS_NUM cores done
- exit_code  output  32*NUM_CORES  r3 value captured at exit
- timeout  output  1  sticky; TIMEOUT_CYCLES elapsed without all_done
- putc_valid  output  1  character available
- putc_ready  input  1  sink accepts character
- putc_core  output  $clog2(NUM_CORES)+1  originating core index
- putc_char  output  8  character
- putc_overflow  output  NUM_CORES  sticky; character dropped because FIFO was full
- insn_count  output  CNT_WIDTH*NUM_CORES  retired-instruction counters (optional feature)

Behaviour:
- Reset (rst==0 at a clk edge) clears all state. Outputs after reset: core_done=0, all_done=0, exit_code=0, timeout=0, putc_valid=0, putc_core=0, putc_char=0, putc_overflow=0, insn_count=0, all FIFOs empty, RR pointer=0. Reset mid-operation discards FIFO contents with no output.
- Shadow r3[i] updates when trace_valid[i] & trace_wben[i] & trace_wbreg==3; it takes wbdata on the next edge.
- Hook decode: trace_valid[i] & insn[31:24]==8'h15. K=insn[15:0]. A hook reads the shadow r3 value before any same-cycle write.
- K=1 (exit), core in RUN: core_done[i]<=1, exit_code[i]<=r3[i], state->DONE.
- DONE is terminal until reset. Later exits in DONE are ignored; exit_code does not change.
- K=4 (putc): pushes r3[i][7:0] into FIFO i, in RUN or DONE.
- All other K values are ignored.
- all_done is registered. It is 1 one cycle after popcount(core_done)>=TERM_CROSS_NUM and stays set until reset.
- Timeout: a free-running cycle counter (saturating, width $clog2(TIMEOUT_CYCLES+1)) starts at 0 after reset.
  - timeout<=1 when count==TIMEOUT_CYCLES-1 and all_done==0.
  - timeout stays 0 forever once all_done has been set first.
- FIFO push is accepted if the FIFO is not full, or if the same FIFO is popped in that cycle.
  - Otherwise the character is dropped and putc_overflow[i]<=1 (sticky).
- Output stage is a registered holding slot.
  - putc_valid/putc_core/putc_char stay stable while putc_valid & !putc_ready.
  - The slot loads when it is empty or being drained (putc_ready).
  - Source FIFO: round-robin starting at the core after the last granted one.
  - Minimum latency from hook to putc_valid is 2 cycles.
  - Back-to-back transfers give one char per cycle when putc_ready stays 1.
- Per-core character order is preserved. Inter-core order is only RR-fair.

Optional Feature:
- Macro TRACE_MONITOR_INSN_COUNT_EN.
- Defined: insn_count[i] increments on each trace_valid[i] while core i is in RUN. The exit nop itself is counted. The counter wraps at 2^CNT_WIDTH and freezes in DONE.
- Undefined: counters are not instantiated and insn_count is tied to 0. All other behaviour is identical.

Test Plan:
- NUM_CORES=1: write r3=0x0000002A, then exit nop 0x15000001 -> core_done=1 next cycle, exit_code=0x2A, all_done=1 one cycle later.
- Same cycle: r3 write 0x7 and exit nop on core 0, with prior r3=0x3 -> exit_code=0x3.
- NUM_CORES=4, TERM_CROSS_NUM=3: cores 0,2,3 exit -> all_done rises 1 cycle after the third exit. A second exit on core 2 with a new r3 leaves exit_code[2] unchanged.
- Cores 0 and 1 each emit "AB" via 0x15000004 in the same cycles with putc_ready=1 -> 4 chars out, per-core order A then B, cores alternating. Holding putc_ready=0 for 5 cycles keeps outputs stable.
- PUTC_FIFO_DEPTH=4, putc_ready=0, 6 putcs on core 1 -> putc_overflow[1]=1. Releasing ready yields 5 chars (4 FIFO + 1 slot) in order.
- TIMEOUT_CYCLES=100, no exit -> timeout=1 at cycle 100 after reset release. Rerun with all_done at cycle 50 -> timeout stays 0. With TRACE_MONITOR_INSN_COUNT_EN, 10 valids then exit -> insn_count=11 and frozen.
